// File: rtl/rocc_resp_queue_pkg.sv
// Shared types and defaults for the RoCC response queue.
package rocc_pkg;

    localparam int unsigned TRANS_ID_BITS   = 3;
    localparam int unsigned ROCC_RESP_DEPTH = 4;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } rocc_resp_state_e;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              result;
    } rocc_wb_t;

endpackage

// File: rtl/rocc_resp_queue_if.sv
// Command, response and writeback signals of the RoCC response queue.
interface rocc_resp_queue_if #(
    parameter int unsigned TRANS_ID_BITS = 3
);

    logic                     flush_i;
    logic                     cmd_fire_i;
    logic                     cmd_has_rd_i;
    logic [TRANS_ID_BITS-1:0] cmd_trans_id_i;
    logic                     cmd_ready_o;
    logic                     resp_valid_i;
    logic [63:0]              resp_data_i;
    logic                     resp_ready_o;
    logic                     wb_valid_o;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic [63:0]              wb_result_o;
    logic                     wb_ready_i;
    logic                     err_unexpected_o;

    modport slave (
        input  flush_i, cmd_fire_i, cmd_has_rd_i, cmd_trans_id_i,
        input  resp_valid_i, resp_data_i, wb_ready_i,
        output cmd_ready_o, resp_ready_o, wb_valid_o, wb_trans_id_o,
        output wb_result_o, err_unexpected_o
    );

    modport master (
        output flush_i, cmd_fire_i, cmd_has_rd_i, cmd_trans_id_i,
        output resp_valid_i, resp_data_i, wb_ready_i,
        input  cmd_ready_o, resp_ready_o, wb_valid_o, wb_trans_id_o,
        input  wb_result_o, err_unexpected_o
    );

endinterface

// File: rtl/rocc_resp_queue_tag_fifo.sv
// Tag FIFO holding trans_ids of commands that still owe a response.
module rocc_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Flush wins over push/pop: the whole queue is abandoned at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rocc_resp_queue.sv
// Matches accelerator responses to outstanding trans_ids in order and drains
// responses of flushed commands without writing them back.
module rocc_resp_queue #(
    parameter int unsigned DEPTH         = rocc_pkg::ROCC_RESP_DEPTH,
    parameter int unsigned TRANS_ID_BITS = rocc_pkg::TRANS_ID_BITS
) (
    input logic               clk_i,
    input logic               rst_ni,
    rocc_resp_queue_if.slave  bus
);

    import rocc_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH+1);

    rocc_resp_state_e         state_q;
    logic [CW-1:0]            drop_cnt_q;
    logic [CW-1:0]            count;
    logic [CW-1:0]            flush_cnt;
    logic [TRANS_ID_BITS-1:0] head;
    logic [TRANS_ID_BITS-1:0] wb_id_q;
    logic [63:0]              wb_data_q;
    logic                     wb_valid_q;
    logic                     err_q;
    logic                     full;
    logic                     empty;
    logic                     normal;
    logic                     push;
    logic                     pop;
    logic                     resp_fire;

    assign normal            = (state_q == NORMAL);
    assign bus.cmd_ready_o   = ~full & normal;
    assign bus.resp_ready_o  = normal ? (~empty & (~wb_valid_q | bus.wb_ready_i)) : 1'b1;
    assign resp_fire         = bus.resp_valid_i & bus.resp_ready_o;
    assign push              = bus.cmd_fire_i & bus.cmd_has_rd_i & bus.cmd_ready_o;
    assign pop               = resp_fire & normal;
    // Responses still owed after this cycle; push is blocked when full so this never exceeds DEPTH.
    assign flush_cnt         = count - CW'(pop) + CW'(push);

    assign bus.wb_valid_o       = wb_valid_q;
    assign bus.wb_trans_id_o    = wb_id_q;
    assign bus.wb_result_o      = wb_data_q;
    assign bus.err_unexpected_o = err_q;

    rocc_tag_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRANS_ID_BITS)
    ) u_tag_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush_i),
        .din   (bus.cmd_trans_id_i),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= NORMAL;
            drop_cnt_q <= '0;
            wb_valid_q <= 1'b0;
            wb_id_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (normal & bus.resp_valid_i & empty) err_q <= 1'b1;
            // A flush while draining is ignored; only the running drop count matters.
            if (!normal) begin
                if (resp_fire && drop_cnt_q != '0) begin
                    drop_cnt_q <= drop_cnt_q - CW'(1);
                    if (drop_cnt_q == CW'(1)) state_q <= NORMAL;
                end
            end else if (bus.flush_i) begin
                wb_valid_q <= 1'b0;
                drop_cnt_q <= flush_cnt;
                if (flush_cnt != '0) state_q <= DRAIN;
            end else if (pop) begin
                wb_valid_q <= 1'b1;
                wb_id_q    <= head;
                wb_data_q  <= bus.resp_data_i;
            end else if (bus.wb_ready_i) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rocc_resp_queue.sv
// Directed and randomized checks of rocc_resp_queue against a queue-based model.
module tb_rocc_resp_queue;

    import rocc_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    rocc_resp_queue_if #(.TRANS_ID_BITS(3)) bus ();

    rocc_resp_queue #(
        .DEPTH         (DEPTH),
        .TRANS_ID_BITS (3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding tags, responses still to discard, pending writeback.
    logic [2:0] tags[$];
    int         m_drop;
    bit         m_wb_valid;
    rocc_wb_t   m_wb;
    bit         m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tags.delete();
        m_drop     = 0;
        m_wb_valid = 1'b0;
        m_wb       = '0;
        m_err      = 1'b0;
    endtask

    task automatic cycle();
        bit exp_cmd_rdy;
        bit exp_resp_rdy;
        bit acc;
        bit psh;
        @(negedge clk);
        exp_cmd_rdy  = (tags.size() < DEPTH) && (m_drop == 0);
        exp_resp_rdy = (m_drop != 0) ? 1'b1
                     : (tags.size() != 0) && (!m_wb_valid || bus.wb_ready_i);
        chk("cmd_ready", 64'(bus.cmd_ready_o), 64'(exp_cmd_rdy));
        chk("resp_ready", 64'(bus.resp_ready_o), 64'(exp_resp_rdy));
        acc = bus.resp_valid_i && exp_resp_rdy;
        psh = bus.cmd_fire_i && bus.cmd_has_rd_i && exp_cmd_rdy;
        if (m_drop != 0) begin
            if (acc) m_drop--;
        end else begin
            if (bus.resp_valid_i && tags.size() == 0) m_err = 1'b1;
            if (bus.flush_i) begin
                m_drop = tags.size() - int'(acc) + int'(psh);
                tags.delete();
                m_wb_valid = 1'b0;
            end else begin
                if (m_wb_valid && bus.wb_ready_i) m_wb_valid = 1'b0;
                if (acc) begin
                    m_wb.trans_id = tags.pop_front();
                    m_wb.result   = bus.resp_data_i;
                    m_wb_valid    = 1'b1;
                end
                if (psh) tags.push_back(bus.cmd_trans_id_i);
            end
        end
        @(posedge clk);
        #1;
        chk("wb_valid", 64'(bus.wb_valid_o), 64'(m_wb_valid));
        if (m_wb_valid) begin
            chk("wb_trans_id", 64'(bus.wb_trans_id_o), 64'(m_wb.trans_id));
            chk("wb_result", bus.wb_result_o, m_wb.result);
        end
        chk("err_unexpected", 64'(bus.err_unexpected_o), 64'(m_err));
        chk("drop_cnt", 64'(dut.drop_cnt_q), 64'(m_drop));
    endtask

    task automatic step(input bit fire, input bit rd, input logic [2:0] id, input bit rv,
                        input logic [63:0] d, input bit wbr, input bit fl);
        bus.cmd_fire_i     = fire;
        bus.cmd_has_rd_i   = rd;
        bus.cmd_trans_id_i = id;
        bus.resp_valid_i   = rv;
        bus.resp_data_i    = d;
        bus.wb_ready_i     = wbr;
        bus.flush_i        = fl;
        cycle();
    endtask

    // Inputs are left as the caller set them so reset is shown to override traffic.
    task automatic reset_dut();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
        chk("rst_resp_ready", 64'(bus.resp_ready_o), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("rst_wb_trans_id", 64'(bus.wb_trans_id_o), 64'd0);
        chk("rst_wb_result", bus.wb_result_o, 64'd0);
        chk("rst_err", 64'(bus.err_unexpected_o), 64'd0);
        chk("rst_drop_cnt", 64'(dut.drop_cnt_q), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.flush_i        = 1'b0;
        bus.cmd_fire_i     = 1'b0;
        bus.cmd_has_rd_i   = 1'b0;
        bus.cmd_trans_id_i = '0;
        bus.resp_valid_i   = 1'b0;
        bus.resp_data_i    = '0;
        bus.wb_ready_i     = 1'b0;
        model_reset();
        reset_dut();

        // In-order matching, one cycle latency.
        step(1, 1, 3'd2, 0, 64'h0, 1, 0);
        step(1, 1, 3'd5, 0, 64'h0, 1, 0);
        step(0, 0, 3'd0, 1, 64'hAA, 1, 0);
        chk("order0_id", 64'(bus.wb_trans_id_o), 64'd2);
        chk("order0_data", bus.wb_result_o, 64'hAA);
        step(0, 0, 3'd0, 1, 64'hBB, 1, 0);
        chk("order1_id", 64'(bus.wb_trans_id_o), 64'd5);
        chk("order1_data", bus.wb_result_o, 64'hBB);
        step(0, 0, 3'd0, 0, 64'h0, 1, 0);

        // Full: fifth command ignored; a pop reopens the queue next cycle.
        for (int i = 0; i < DEPTH; i++) step(1, 1, 3'(i), 0, 64'h0, 1, 0);
        chk("full_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        step(1, 1, 3'd7, 0, 64'h0, 1, 0);
        step(0, 0, 3'd0, 1, 64'h11, 1, 0);
        chk("full_reopen", 64'(bus.cmd_ready_o), 64'd1);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 3'd0, 1, 64'(32'h100 + i), 1, 0);
        step(0, 0, 3'd0, 0, 64'h0, 1, 0);

        // Back-pressure: writeback held three cycles, then released.
        step(1, 1, 3'd1, 0, 64'h0, 1, 0);
        step(1, 1, 3'd2, 0, 64'h0, 1, 0);
        step(0, 0, 3'd0, 1, 64'h21, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 3'd0, 1, 64'h22, 0, 0);
            chk("bp_hold_data", bus.wb_result_o, 64'h21);
        end
        step(0, 0, 3'd0, 1, 64'h22, 1, 0);
        chk("bp_release_id", 64'(bus.wb_trans_id_o), 64'd2);
        step(0, 0, 3'd0, 0, 64'h0, 1, 0);

        // Flush with three outstanding and no response.
        step(1, 1, 3'd3, 0, 64'h0, 1, 0);
        step(1, 1, 3'd4, 0, 64'h0, 1, 0);
        step(1, 1, 3'd6, 0, 64'h0, 1, 0);
        step(0, 0, 3'd0, 0, 64'h0, 1, 1);
        chk("flush_drop3", 64'(dut.drop_cnt_q), 64'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 1, 64'(32'h300 + i), 1, 0);
        chk("flush_done_ready", 64'(bus.cmd_ready_o), 64'd1);

        // Flush coinciding with a response accept and a push.
        step(1, 1, 3'd1, 0, 64'h0, 1, 0);
        step(1, 1, 3'd2, 0, 64'h0, 1, 0);
        step(1, 1, 3'd7, 1, 64'h55, 1, 1);
        chk("flush_mix_drop", 64'(dut.drop_cnt_q), 64'd2);
        chk("flush_mix_wb", 64'(bus.wb_valid_o), 64'd0);
        step(0, 0, 3'd0, 1, 64'h56, 1, 0);
        step(0, 0, 3'd0, 1, 64'h57, 1, 0);

        // Unexpected response: sticky until reset.
        step(0, 0, 3'd0, 1, 64'h99, 1, 0);
        chk("unexp_set", 64'(bus.err_unexpected_o), 64'd1);
        step(0, 0, 3'd0, 0, 64'h0, 1, 0);
        chk("unexp_sticky", 64'(bus.err_unexpected_o), 64'd1);
        reset_dut();

        // Randomized traffic, including flushes and resets under load.
        for (int n = 0; n < 3000; n++) begin
            bus.cmd_fire_i     = ($urandom_range(0, 1) == 1);
            bus.cmd_has_rd_i   = ($urandom_range(0, 3) != 0);
            bus.cmd_trans_id_i = 3'($urandom);
            bus.resp_valid_i   = ($urandom_range(0, 1) == 1);
            bus.resp_data_i    = {$urandom, $urandom};
            bus.wb_ready_i     = ($urandom_range(0, 9) < 7);
            bus.flush_i        = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) reset_dut();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
